// File: rtl/uart_hex_reporter.sv
// uart_hex_reporter
//   Turns each accepted result into uppercase ASCII hex text (most-significant
//   nibble first, optional CR LF) and feeds it byte by byte to uart_tx.
//
// Parameters
//   NB_DATA  : result width, multiple of 4 in 4..32 (ND = NB_DATA/4 digits)
//   ADD_CRLF : 1 appends 0x0D 0x0A after the last digit
//   NB_CHAR  : width of the byte handed to uart_tx (8)
//
// Ports
//   clk        : system clock
//   i_rst_n    : asynchronous active-low reset
//   i_valid    : one-cycle strobe, i_result valid this cycle
//   i_result   : value to report
//   i_txDone   : one-cycle pulse from uart_tx, current byte finished
//   o_tx_start : one-cycle request to transmit o_data
//   o_data     : ASCII byte to transmit, stable for the whole byte
//   o_busy     : high while a report is in progress
//   o_drop     : one-cycle pulse, an i_valid arrived while busy and was lost
module uart_hex_reporter #(
    parameter int NB_DATA  = 8,
    parameter int ADD_CRLF = 1,
    parameter int NB_CHAR  = 8
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_result,
    input  logic               i_txDone,
    output logic               o_tx_start,
    output logic [NB_CHAR-1:0] o_data,
    output logic               o_busy,
    output logic               o_drop
);

    localparam int ND = NB_DATA / 4;
    localparam int NC = ND + 2 * ADD_CRLF;
    localparam int IW = (NC > 1) ? $clog2(NC) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NB_DATA-1:0] cap_q, cap_d;
    logic               busy_q, busy_d;
    logic               drop_q, drop_d;

    logic [3:0]         nib;
    logic [7:0]         chr;

    // Character for the current index: digits first (MS nibble at index 0),
    // then CR and LF. Index compared as int so ND == 2**IW cannot alias to 0.
    always_comb begin
        nib = '0;
        for (int unsigned i = 0; i < ND; i++) begin
            if (int'(idx_q) == ND - 1 - int'(i)) begin
                nib = cap_q[4*i +: 4];
            end
        end
        if (int'(idx_q) < ND) begin
            chr = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        end else if (int'(idx_q) == ND) begin
            chr = 8'h0D;
        end else begin
            chr = 8'h0A;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        busy_d  = busy_q;
        // Busy is the registered flag, so a strobe coinciding with the final
        // txDone is still seen as busy and dropped.
        drop_d  = i_valid && busy_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    cap_d   = i_result;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_txDone) begin
                    if (idx_q == IW'(NC - 1)) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_START;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cap_q   <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    assign o_tx_start = (state_q == S_START);
    assign o_data     = (state_q == S_IDLE) ? '0 : NB_CHAR'(chr);
    assign o_busy     = busy_q;
    assign o_drop     = drop_q;

endmodule

// File: tb/tb_uart_hex_reporter.sv
module tb_uart_hex_reporter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance with CR LF
    logic        v8 = 1'b0, d8 = 1'b0;
    logic [7:0]  r8 = '0;
    logic        s8, b8, dr8;
    logic [7:0]  o8;
    // 16-bit instance, digits only
    logic        v16 = 1'b0, d16 = 1'b0;
    logic [15:0] r16 = '0;
    logic        s16, b16, dr16;
    logic [7:0]  o16;

    uart_hex_reporter #(.NB_DATA(8), .ADD_CRLF(1), .NB_CHAR(8)) dut8 (
        .clk(clk), .i_rst_n(rst_n), .i_valid(v8), .i_result(r8), .i_txDone(d8),
        .o_tx_start(s8), .o_data(o8), .o_busy(b8), .o_drop(dr8)
    );
    uart_hex_reporter #(.NB_DATA(16), .ADD_CRLF(0), .NB_CHAR(8)) dut16 (
        .clk(clk), .i_rst_n(rst_n), .i_valid(v16), .i_result(r16), .i_txDone(d16),
        .o_tx_start(s16), .o_data(o16), .o_busy(b16), .o_drop(dr16)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // mode 0: plain, 1: extra i_valid during 2nd char, 2: i_valid with final txDone
    typedef struct {
        bit          wide;
        logic [15:0] res;
        logic [31:0] exp;
        int          mode;
    } vec_t;

    function automatic logic cur_start(input bit w); return w ? s16 : s8; endfunction
    function automatic logic [7:0] cur_data(input bit w); return w ? o16 : o8; endfunction
    function automatic logic cur_busy(input bit w); return w ? b16 : b8; endfunction
    function automatic logic cur_drop(input bit w); return w ? dr16 : dr8; endfunction

    task automatic drive(input bit w, input logic v, input logic [15:0] r, input logic d);
        if (w) begin v16 = v; r16 = r; d16 = d; end
        else begin v8 = v; r8 = r[7:0]; d8 = d; end
    endtask

    task automatic run_report(input vec_t t);
        int lat;
        logic [7:0] ch;
        drive(t.wide, 1'b1, t.res, 1'b0);
        @(negedge clk);
        // changing the input after capture must not affect the text
        drive(t.wide, 1'b0, ~t.res, 1'b0);
        for (int k = 0; k < 4; k++) begin
            ch = t.exp[31-8*k -: 8];
            lat = 0;
            while (!cur_start(t.wide) && lat < 8) begin
                @(negedge clk);
                lat++;
            end
            check("start_latency", lat, 0);
            check("char", cur_data(t.wide), ch);
            check("busy_during", cur_busy(t.wide), 1);
            @(negedge clk);
            check("start_one_cycle", cur_start(t.wide), 0);
            check("char_hold", cur_data(t.wide), ch);
            if (t.mode == 1 && k == 1) begin
                drive(t.wide, 1'b1, 16'h0000, 1'b0);
                @(negedge clk);
                drive(t.wide, 1'b0, 16'h0000, 1'b0);
                check("drop_pulse", cur_drop(t.wide), 1);
                @(negedge clk);
                check("drop_single", cur_drop(t.wide), 0);
                check("no_start_after_drop", cur_start(t.wide), 0);
                check("char_after_drop", cur_data(t.wide), ch);
            end
            if (t.mode == 2 && k == 3) begin
                drive(t.wide, 1'b1, 16'h0055, 1'b1);
                @(negedge clk);
                drive(t.wide, 1'b0, 16'h0055, 1'b0);
                check("drop_at_final_done", cur_drop(t.wide), 1);
                check("busy_fall_final", cur_busy(t.wide), 0);
                check("no_start_final", cur_start(t.wide), 0);
                @(negedge clk);
                check("not_accepted", cur_start(t.wide), 0);
                check("idle_busy", cur_busy(t.wide), 0);
                check("drop_cleared", cur_drop(t.wide), 0);
            end else begin
                drive(t.wide, 1'b0, ~t.res, 1'b1);
                @(negedge clk);
                drive(t.wide, 1'b0, ~t.res, 1'b0);
            end
        end
        if (t.mode != 2) begin
            check("busy_fall", cur_busy(t.wide), 0);
            check("no_start_end", cur_start(t.wide), 0);
        end
        @(negedge clk);
    endtask

    vec_t tbl[8];
    int   nstart;
    logic [7:0] seen[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 16'h003C, 32'h33430D0A, 0};
        tbl[1] = '{1'b0, 16'h0009, 32'h30390D0A, 0};
        tbl[2] = '{1'b0, 16'h00FF, 32'h46460D0A, 0};
        tbl[3] = '{1'b0, 16'h00A5, 32'h41350D0A, 1};
        tbl[4] = '{1'b0, 16'h007B, 32'h37420D0A, 2};
        tbl[5] = '{1'b1, 16'hBEEF, 32'h42454546, 0};
        tbl[6] = '{1'b1, 16'h1209, 32'h31323039, 0};
        tbl[7] = '{1'b0, 16'h0000, 32'h30300D0A, 0};

        // reset state
        repeat (2) @(negedge clk);
        check("rst_start", s8, 0);
        check("rst_data", o8, 8'h00);
        check("rst_busy", b8, 0);
        check("rst_drop", dr8, 0);
        check("rst_busy16", b16, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) run_report(tbl[i]);

        // txDone while idle is ignored
        d8 = 1'b1;
        repeat (2) @(negedge clk);
        d8 = 1'b0;
        check("idle_done_start", s8, 0);
        check("idle_done_busy", b8, 0);

        // txDone during START is ignored: 0x5E, done overlapping first start
        v8 = 1'b1; r8 = 8'h5E;
        @(negedge clk);
        v8 = 1'b0;
        check("start_ign_c0", o8, 8'h35);
        check("start_ign_s0", s8, 1);
        d8 = 1'b1;
        @(negedge clk);
        d8 = 1'b0;
        check("start_ign_no_adv", s8, 0);
        check("start_ign_hold", o8, 8'h35);
        @(negedge clk);
        check("start_ign_wait", s8, 0);
        for (int k = 1; k < 4; k++) begin
            d8 = 1'b1;
            @(negedge clk);
            d8 = 1'b0;
            check("start_ign_next_s", s8, 1);
            check("start_ign_next_c", o8, (k == 1) ? 8'h45 : (k == 2) ? 8'h0D : 8'h0A);
            @(negedge clk);
        end
        d8 = 1'b1;
        @(negedge clk);
        d8 = 1'b0;
        check("start_ign_busy", b8, 0);
        @(negedge clk);

        // txDone held high for 5 cycles in WAIT: 0x3C
        v8 = 1'b1; r8 = 8'h3C;
        @(negedge clk);
        v8 = 1'b0;
        check("held_c0", o8, 8'h33);
        @(negedge clk);
        seen.delete();
        d8 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (s8) seen.push_back(o8);
        end
        d8 = 1'b0;
        check("held_nstarts", seen.size(), 3);
        if (seen.size() == 3) begin
            check("held_c1", seen[0], 8'h43);
            check("held_c2", seen[1], 8'h0D);
            check("held_c3", seen[2], 8'h0A);
        end
        @(negedge clk);
        check("held_busy", b8, 1);
        check("held_no_start", s8, 0);
        d8 = 1'b1;
        @(negedge clk);
        d8 = 1'b0;
        check("held_busy_fall", b8, 0);
        @(negedge clk);

        // asynchronous reset while waiting for the 3rd txDone
        v8 = 1'b1; r8 = 8'h3C;
        @(negedge clk);
        v8 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            d8 = 1'b1;
            @(negedge clk);
            d8 = 1'b0;
        end
        check("pre_rst_c2", o8, 8'h0D);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_start", s8, 0);
        check("arst_data", o8, 8'h00);
        check("arst_busy", b8, 0);
        check("arst_drop", dr8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nstart = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (s8 || b8) nstart++;
        end
        check("post_rst_quiet", nstart, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_hex_reporter.md
Name: uart_hex_reporter

Overview:
- Downstream stage for the UART/ALU top level. Takes each ALU result and the strobe that marks it valid.
- Serialises the result as uppercase ASCII hex, most-significant nibble first, optionally followed by CR LF.
- Drives the uart_tx handshake (start pulse plus byte in, done pulse out), so the host terminal sees results as readable text rather than raw bytes.

Parameters:
- NB_DATA, 8, result width in bits; must be a multiple of 4, range 4..32; digit count ND = NB_DATA/4.
- ADD_CRLF, 1, when 1 append 0x0D then 0x0A after the last digit; when 0 send digits only.
- NB_CHAR, 8, width of the byte sent to uart_tx (fixed at 8).

Ports:
- clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  one-cycle strobe: i_result is valid this cycle
- i_result  in  NB_DATA  value to report
- i_txDone  in  1  one-cycle pulse from uart_tx: current byte finished
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_data
- o_data  out  NB_CHAR  ASCII byte to transmit
- o_busy  out  1  high while a report is in progress
- o_drop  out  1  one-cycle pulse: i_valid arrived while busy and was discarded

Behaviour:
- Reset (i_rst_n low, asynchronous, any time, including mid-report):
  - State goes to IDLE; character index and capture register clear.
  - o_tx_start=0, o_data=0x00, o_busy=0, o_drop=0.
  - No start pulse is issued after reset releases until a new i_valid.
- Clock and reset: one clock; reset is asynchronous and active-low.
- Total characters per report: NC = ND + 2*ADD_CRLF (8-bit default: 4 characters, "HH\r\n").
- ASCII map per nibble: 0..9 -> 0x30..0x39, 10..15 -> 0x41..0x46 (uppercase only).
- States: IDLE, START, WAIT.
- IDLE:
  - o_busy=0.
  - On i_valid=1 at a clock edge: capture i_result, index=0, go to START.
- START:
  - Lasts one cycle; o_tx_start=1 and o_data=char(index).
  - Go to WAIT.
- WAIT:
  - o_data holds char(index) stable; o_tx_start=0.
  - On i_txDone=1: if index=NC-1 go to IDLE, else index+1 and go to START.
- o_busy is registered: high from the cycle after the accepting edge until the edge where the final i_txDone is sampled.
- Latency:
  - i_valid sampled at edge N -> o_tx_start high in cycle N..N+1 (first cycle after edge N).
  - Each following start pulse comes one cycle after the corresponding i_txDone is sampled.
- Character order: index 0 is nibble [NB_DATA-1 -: 4], descending to nibble [3:0], then CR, then LF.
- Boundary conditions:
  - i_valid while o_busy=1: discarded; o_drop=1 for the next cycle; the report in progress is unaffected.
  - i_valid in the same cycle as the final i_txDone: discarded (o_busy still 1) and o_drop pulses.
  - i_txDone in IDLE or START: ignored.
  - i_txDone held high for several cycles: only the first WAIT-state sample advances; START always separates two advances.
  - i_result changes during a report: no effect, because the captured copy is used.

Test Plan:
- Reset, then i_valid with i_result=0x3C -> o_tx_start pulses carrying 0x33, 0x43, 0x0D, 0x0A in order, each one cycle after the previous i_txDone; o_busy falls after the 4th i_txDone.
- i_result=0x09 then 0xFF (ADD_CRLF=1) -> sequences 0x30 0x39 0x0D 0x0A and 0x46 0x46 0x0D 0x0A; no lowercase characters.
- i_valid again while the second character of 0xA5 is pending -> o_drop single-cycle pulse; the output stream stays 0x41 0x35 0x0D 0x0A.
- Assert i_rst_n low while waiting for the 3rd i_txDone -> all outputs 0 asynchronously; after release, no o_tx_start appears until a new i_valid.
- NB_DATA=16, ADD_CRLF=0, i_result=0xBEEF -> exactly 4 starts: 0x42, 0x45, 0x45, 0x46; o_busy falls after the 4th i_txDone.
- i_txDone held high for 5 cycles during WAIT -> exactly one character advance per start pulse; no characters skipped.
